// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between two requesters
//   (port 0 = instruction fetch, port 1 = load/store unit). Round-robin
//   grant with valid/ready request handshakes. Each port has a one-entry
//   response slot that holds read data until the requester accepts it.
//
//   Memory timing assumed: the memory samples address/control on the falling
//   clk edge and presents read data before the next rising edge. A read
//   granted in cycle N is therefore captured into the slot at the end of
//   cycle N.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqP_valid/ready           request handshake (ready = grant, combinational)
//   reqP_we/addr/wdata/tag     request payload
//   rspP_valid/ready           response slot handshake
//   rspP_data/tag              held read data and its tag
//   mem_wEn/addr/dataIn        memory drive (from the granted request)
//   mem_dataOut                memory read data
//
// Optional feature (macro ARB_STATS_EN)
//   stat_clear                 synchronous clear of the counters
//   stat_grant0/1              saturating grant counters per port
//   stat_conflict              saturating count of cycles with both ports valid
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned TAG_WIDTH     = 4,
  parameter int unsigned STAT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic                     req0_we,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]    req0_wdata,
  input  logic [TAG_WIDTH-1:0]     req0_tag,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic                     req1_we,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]    req1_wdata,
  input  logic [TAG_WIDTH-1:0]     req1_tag,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic [DATA_WIDTH-1:0]    rsp0_data,
  output logic [TAG_WIDTH-1:0]     rsp0_tag,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp1_data,
  output logic [TAG_WIDTH-1:0]     rsp1_tag,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut
`ifdef ARB_STATS_EN
  ,
  input  logic                     stat_clear,
  output logic [STAT_WIDTH-1:0]    stat_grant0,
  output logic [STAT_WIDTH-1:0]    stat_grant1,
  output logic [STAT_WIDTH-1:0]    stat_conflict
`endif
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_HELD  = 1'b1
  } slot_e;

  slot_e slot0_q, slot0_d;
  slot_e slot1_q, slot1_d;
  logic  prio_q;          // port that wins the next conflict
  logic  elig0, elig1;
  logic  grant0, grant1;
  logic  rd_grant0, rd_grant1;

  // Counter width must be usable even when the counters are compiled out.
  if (STAT_WIDTH < 1) begin : g_stat_width_invalid
  end

  function automatic slot_e slot_next(input slot_e cur, input logic rd_grant,
                                      input logic rsp_ready);
    slot_e nxt;
    nxt = cur;
    case (cur)
      SLOT_EMPTY: if (rd_grant)  nxt = SLOT_HELD;
      SLOT_HELD:  if (rsp_ready) nxt = SLOT_EMPTY;
      default:                   nxt = SLOT_EMPTY;
    endcase
    return nxt;
  endfunction

  // Grant and memory drive.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    grant0     = 1'b0;
    grant1     = 1'b0;
    mem_wEn    = 1'b0;
    mem_addr   = '0;
    mem_dataIn = '0;

    // A read needs a free slot; a held slot stalls the read even if it is
    // being drained this same cycle, so each port has at most one read out.
    elig0 = req0_valid & (req0_we | (slot0_q == SLOT_EMPTY));
    elig1 = req1_valid & (req1_we | (slot1_q == SLOT_EMPTY));

    // Grants are gated by rst_n so an in-flight access is dropped the moment
    // reset asserts, not at the next edge.
    if (rst_n) begin
      if (elig0 && elig1) begin
        grant0 = ~prio_q;
        grant1 =  prio_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end

    if (grant0) begin
      mem_wEn    = req0_we;
      mem_addr   = req0_addr;
      mem_dataIn = req0_we ? req0_wdata : '0;
    end else if (grant1) begin
      mem_wEn    = req1_we;
      mem_addr   = req1_addr;
      mem_dataIn = req1_we ? req1_wdata : '0;
    end

    rd_grant0 = grant0 & ~req0_we;
    rd_grant1 = grant1 & ~req1_we;
    slot0_d   = slot_next(slot0_q, rd_grant0, rsp0_ready);
    slot1_d   = slot_next(slot1_q, rd_grant1, rsp1_ready);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (slot0_q == SLOT_HELD);
  assign rsp1_valid = (slot1_q == SLOT_HELD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q   <= SLOT_EMPTY;
      slot1_q   <= SLOT_EMPTY;
      prio_q    <= 1'b0;
      rsp0_data <= '0;
      rsp0_tag  <= '0;
      rsp1_data <= '0;
      rsp1_tag  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      if (grant0)      prio_q <= 1'b1;
      else if (grant1) prio_q <= 1'b0;
      // Capture only on the granted read; data and tag stay frozen while held.
      if (rd_grant0) begin
        rsp0_data <= mem_dataOut;
        rsp0_tag  <= req0_tag;
      end
      if (rd_grant1) begin
        rsp1_data <= mem_dataOut;
        rsp1_tag  <= req1_tag;
      end
    end
  end

`ifdef ARB_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

  logic conflict;
  assign conflict = req0_valid & req1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else if (stat_clear) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (grant0 && (stat_grant0 != '1))     stat_grant0   <= stat_grant0 + STAT_ONE;
      if (grant1 && (stat_grant1 != '1))     stat_grant1   <= stat_grant1 + STAT_ONE;
      if (conflict && (stat_conflict != '1)) stat_conflict <= stat_conflict + STAT_ONE;
    end
  end
`endif

endmodule
